// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Optional round-robin arbitration is enabled by defining BUS_ARB_RR_EN.
package bus_pkg;

    localparam int ADDR_W      = 22;
    localparam int DATA_W      = 32;
    localparam int WDT_W       = 16;
    localparam int TMO_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    function automatic state_t grant_of(input logic sel);
        return sel ? G1 : G0;
    endfunction

endpackage

// File: rtl/bus_arb_wdt.sv
// Transfer watchdog: counts stalled cycles of the granted master and fires
// on the stalled cycle that reaches TMO_CYCLES.
module bus_arb_wdt
    import bus_pkg::*;
#(
    parameter int TMO_CYCLES = TMO_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic fire
);

    localparam logic [WDT_W-1:0] LAST = WDT_W'(TMO_CYCLES - 1);

    logic [WDT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The firing cycle is itself a stalled cycle, so compare one short.
    assign fire = inc && (cnt == LAST);

endmodule

// File: rtl/bus_arb.sv
// Two-master bus arbiter (m0 = CPU, m1 = DMA/video) with lock and watchdog.
// Define BUS_ARB_RR_EN for round-robin contention; default is fixed m0 priority.
//
// state | meaning
// IDLE  | no owner, bus_stb low, arbitrate pending requests
// G0    | m0 owns the bus
// G1    | m1 owns the bus
module bus_arb
    import bus_pkg::*;
#(
    parameter int TMO_CYCLES = TMO_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    output logic [DATA_W-1:0] m0_din,
    output logic              m0_ack,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic [DATA_W-1:0] m1_din,
    output logic              m1_ack,
    output logic              bus_stb,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din,
    input  logic              bus_ack,
    output logic [1:0]        gnt,
    output logic              tmo
);

    state_t state, state_next;

    logic              sel;
    logic              owned;
    logic              own_stb;
    logic              own_we;
    logic              own_lock;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_dout;
    logic              other_stb;
    logic              fire;
    logic              release_now;
    logic              wdt_clr;
    logic              wdt_inc;
    logic              pick;

    assign sel       = (state == G1);
    assign owned     = (state != IDLE);
    assign own_stb   = sel ? m1_stb  : m0_stb;
    assign own_we    = sel ? m1_we   : m0_we;
    assign own_lock  = sel ? m1_lock : m0_lock;
    assign own_addr  = sel ? m1_addr : m0_addr;
    assign own_dout  = sel ? m1_dout : m0_dout;
    assign other_stb = sel ? m0_stb  : m1_stb;

    // A timeout ends the transfer regardless of lock.
    assign release_now = fire || (bus_ack && !own_lock);

`ifdef BUS_ARB_RR_EN
    // Holds the master that wins the next contention, i.e. the one that was
    // not released last; m0 is favoured out of reset.
    logic rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (owned && own_stb && release_now) begin
            rr_ptr <= ~sel;
        end
    end

    assign pick = rr_ptr;
`else
    assign pick = 1'b0;
`endif

    assign wdt_inc = owned && own_stb && !bus_ack;
    assign wdt_clr = !owned || bus_ack || (state_next != state);

    bus_arb_wdt #(
        .TMO_CYCLES(TMO_CYCLES)
    ) u_wdt (
        .clk (clk),
        .rst (rst),
        .clr (wdt_clr),
        .inc (wdt_inc),
        .fire(fire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus_stb    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_dout   = '0;
        m0_ack     = 1'b0;
        m0_din     = '0;
        m1_ack     = 1'b0;
        m1_din     = '0;
        gnt        = {state == G1, state == G0};
        tmo        = fire;

        case (state)
            IDLE: begin
                if (m0_stb && m1_stb) begin
                    state_next = grant_of(pick);
                end else if (m0_stb) begin
                    state_next = G0;
                end else if (m1_stb) begin
                    state_next = G1;
                end
            end
            G0, G1: begin
                if (!own_stb) begin
                    state_next = IDLE;
                end else if (release_now) begin
                    state_next = other_stb ? grant_of(~sel) : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (owned) begin
            bus_stb  = own_stb;
            bus_we   = own_we;
            bus_addr = own_addr;
            bus_dout = own_dout;
            if (sel) begin
                m1_ack = bus_ack || fire;
                m1_din = fire ? '0 : bus_din;
            end else begin
                m0_ack = bus_ack || fire;
                m0_din = fire ? '0 : bus_din;
            end
        end
    end

endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 Parameter TMO_CYCLES, default 255, cycles a granted master waits for bus_ack before the watchdog ends the transfer (range 2..65535).
REQ-002 Ports, clock and reset first:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_stb / m1_stb  in  1  master request strobe; m0 is the CPU side, m1 is the DMA/video side.
- m0_we / m1_we  in  1  write enable.
- m0_lock / m1_lock  in  1  keep grant across the next ack (read-modify-write).
- m0_addr / m1_addr  in  22  word address [23:2].
- m0_dout / m1_dout  in  32  write data.
- m0_din / m1_din  out  32  read data.
- m0_ack / m1_ack  out  1  transfer done.
- bus_stb  out  1  slave strobe.
- bus_we  out  1  slave write enable.
- bus_addr  out  22  slave address.
- bus_dout  out  32  slave write data.
- bus_din  in  32  slave read data.
- bus_ack  in  1  slave ack.
- gnt  out  2  one-hot grant {m1,m0}.
- tmo  out  1  one-cycle pulse when the watchdog fires.

Function
REQ-003 States: IDLE, G0 (m0 owns the bus), G1 (m1 owns the bus); the state register is the only grant source, and gnt decodes it.
REQ-004 IDLE: no request -> stay; one request -> grant that master next cycle; both request -> apply the priority rule (REQ-010); one cycle of arbitration latency.
REQ-005 Gx: bus_stb/we/addr/dout = mx_*, mux combinational; mx_din = bus_din; mx_ack = bus_ack.
- The other master's ack = 0; its din is don't-care, driven 0.
REQ-006 Gx, bus_ack=1, mx_lock=1 -> stay in Gx, grant is not re-arbitrated.
REQ-007 Gx, bus_ack=1, mx_lock=0 -> go to G(other) if the other master requests, else IDLE; handoff has no dead cycle.
REQ-008 Gx, mx_stb=0 (request withdrawn) -> IDLE next cycle; bus_stb follows mx_stb combinationally.
REQ-009 Watchdog counter, 16 bit:
- Cleared on entry to Gx and on every bus_ack.
- Increments each Gx cycle with bus_stb=1 and bus_ack=0.
- On reaching TMO_CYCLES: mx_ack=1 with mx_din=32'h0 for one cycle, tmo=1, lock ignored, leave per REQ-007.
REQ-010 Priority when both request: m0 wins (fixed priority) unless BUS_ARB_RR_EN is defined (REQ-014).
REQ-011 bus_ack arriving in IDLE is ignored; bus_stb=0 in IDLE.

Reset
REQ-012 While rst=1, asynchronously: state=IDLE, counter=0, RR pointer=m0.
- All outputs 0: bus_stb, bus_we, bus_addr, bus_dout, gnt, m0/m1_ack, m0/m1_din, tmo.
REQ-013 A transfer in flight at reset is aborted: no ack to either master; the first grant after release follows REQ-004.

Configuration
REQ-014 Macro BUS_ARB_RR_EN:
- Defined: round-robin; a 1-bit pointer names the last master released with lock=0, and on contention the other master wins.
- Undefined: fixed m0 priority, no pointer register.

Structure
REQ-015 Shared package bus_pkg holds:
- State encodings IDLE=2'b00, G0=2'b01, G1=2'b10.
- Widths ADDR_W=22, DATA_W=32.
- TMO default.
REQ-016 One sub-module, bus_arb_wdt (watchdog counter plus compare); the mux and FSM stay in bus_arb.

Verification
REQ-017 m0 read only, addr 22'h000100, slave acks on cycle 3 with 32'hDEADBEEF:
- gnt=01 one cycle after m0_stb.
- m0_din=DEADBEEF with m0_ack.
- IDLE next cycle.
REQ-018 m0 and m1 request in the same cycle, both lock=0, each acked after 1 cycle:
- Fixed priority: order m0,m1.
- RR: order m0,m1,m0,m1 for 4 back-to-back requests.
REQ-019 m0 RMW with lock=1 on the read and lock=0 on the write, while m1 requests throughout:
- gnt stays 01 through both acks.
- gnt=10 on the cycle after the write ack.
REQ-020 TMO_CYCLES=4, m1 write, slave never acks:
- tmo=1 and m1_ack=1 with m1_din=0 on the 4th stalled cycle.
- Then IDLE.
REQ-021 rst asserted mid-G1, before ack:
- All outputs 0 in the same cycle, no m1_ack.
- After release with m1_stb still high, gnt=10 one cycle later.
